hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage MIPS core. It holds a scoreboard shadow of the E, M and W stages: destination register, write enable and remaining Tnew. It compares that shadow against the source operands and Tuse of the instruction in D. From this it drives the single `stall` line consumed by the IF/ID and ID/EXE registers, plus forwarding selects for D- and E-stage operands. It also sequences the multiply/divide unit's busy window, so that HI/LO accessors wait.

---
 rtl/hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_hazard_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: E/M/W scoreboard shadow, stall and forwarding
// selects for the D and E operands, and the mult/div busy window.
//
// md_state | meaning
// IDLE     | md_cnt = 0; HI/LO is free unless a mult/div sits in E
// BUSY     | md_cnt > 0; a mult/div left E and HI/LO accessors must wait
module hazard_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_D,
    input  logic [4:0] rt_D,
    input  logic [1:0] Tuse_rs_D,
    input  logic [1:0] Tuse_rt_D,
    input  logic [4:0] A3_D,
    input  logic       RegWr_D,
    input  logic [1:0] Tnew_D,
    input  logic       md_start_D,
    input  logic       md_div_D,
    input  logic       md_use_D,
    output logic       stall,
    output logic [1:0] fwd_rs_D,
    output logic [1:0] fwd_rt_D,
    output logic [1:0] fwd_rs_E,
    output logic [1:0] fwd_rt_E,
    output logic       md_busy
);
    localparam int MAXC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, BUSY} md_state_t;

    logic [4:0]  e_a3, e_rs, e_rt, m_a3, w_a3;
    logic        e_wr, m_wr, w_wr, e_md_start, e_md_div;
    logic [1:0]  e_tnew, m_tnew;
    logic [CW-1:0] md_cnt;
    md_state_t   md_state;

    logic [3:0]  near_rs, near_rt;
    logic        stall_rs, stall_rt, stall_md;

    function automatic logic hit(input logic [4:0] r, input logic [4:0] a3, input logic wr);
        return (r != 5'd0) && wr && (a3 == r);
    endfunction

    function automatic logic [1:0] dec_sat(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // {stage, tnew} of the nearest writer; stage 0 = none. W results are always ready.
    function automatic logic [3:0] nearest(input logic he, input logic hm, input logic hw,
                                           input logic [1:0] te, input logic [1:0] tm);
        if (he)      return {2'd1, te};
        else if (hm) return {2'd2, tm};
        else if (hw) return {2'd3, 2'd0};
        else         return 4'd0;
    endfunction

    function automatic logic [1:0] fwd_e(input logic [4:0] r);
        if (hit(r, m_a3, m_wr))      return (m_tnew == 2'd0) ? 2'd2 : 2'd0;
        else if (hit(r, w_a3, w_wr)) return 2'd3;
        else                         return 2'd0;
    endfunction

    always_comb begin
        near_rs = nearest(hit(rs_D, e_a3, e_wr), hit(rs_D, m_a3, m_wr), hit(rs_D, w_a3, w_wr),
                          e_tnew, m_tnew);
        near_rt = nearest(hit(rt_D, e_a3, e_wr), hit(rt_D, m_a3, m_wr), hit(rt_D, w_a3, w_wr),
                          e_tnew, m_tnew);
        stall_rs = (Tuse_rs_D != 2'd3) && (near_rs[3:2] == 2'd1 || near_rs[3:2] == 2'd2)
                   && (near_rs[1:0] > Tuse_rs_D);
        stall_rt = (Tuse_rt_D != 2'd3) && (near_rt[3:2] == 2'd1 || near_rt[3:2] == 2'd2)
                   && (near_rt[1:0] > Tuse_rt_D);
        fwd_rs_D = (near_rs[1:0] == 2'd0) ? near_rs[3:2] : 2'd0;
        fwd_rt_D = (near_rt[1:0] == 2'd0) ? near_rt[3:2] : 2'd0;
        fwd_rs_E = fwd_e(e_rs);
        fwd_rt_E = fwd_e(e_rt);
    end

    assign md_busy  = (md_state == BUSY) || e_md_start;
    assign stall_md = md_use_D && md_busy;
    assign stall    = stall_rs || stall_rt || stall_md;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_a3 <= '0; e_wr <= 1'b0; e_tnew <= '0; e_rs <= '0; e_rt <= '0;
            e_md_start <= 1'b0; e_md_div <= 1'b0;
            m_a3 <= '0; m_wr <= 1'b0; m_tnew <= '0;
            w_a3 <= '0; w_wr <= 1'b0;
        end else begin
            w_a3   <= m_a3;
            w_wr   <= m_wr;
            m_a3   <= e_a3;
            m_wr   <= e_wr;
            m_tnew <= dec_sat(e_tnew);
            if (stall) begin
                e_a3 <= '0; e_wr <= 1'b0; e_tnew <= '0; e_rs <= '0; e_rt <= '0;
                e_md_start <= 1'b0; e_md_div <= 1'b0;
            end else begin
                e_a3       <= A3_D;
                e_wr       <= RegWr_D;
                e_tnew     <= Tnew_D;
                e_rs       <= rs_D;
                e_rt       <= rt_D;
                e_md_start <= md_start_D;
                e_md_div   <= md_div_D;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_state <= IDLE;
            md_cnt   <= '0;
        end else if (e_md_start) begin
            md_state <= BUSY;
            md_cnt   <= e_md_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
        end else if (md_cnt != '0) begin
            md_state <= (md_cnt == CW'(1)) ? IDLE : BUSY;
            md_cnt   <= md_cnt - CW'(1);
        end else begin
            md_state <= IDLE;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: table of D-stage instructions with expected outputs,
// plus hand sequences for mult/div windows and asynchronous reset.
module tb_hazard_ctrl;
    typedef struct {
        logic [4:0] rs, rt, a3;
        logic [1:0] tu_rs, tu_rt, tnew;
        logic       wr, mds, mdd, mdu;
    } din_t;

    typedef struct {
        logic       stall;
        logic [1:0] frsd, frtd, frse, frte;
        logic       busy;
    } dout_t;

    typedef struct {
        din_t  d;
        dout_t q;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] rs_D = '0, rt_D = '0, A3_D = '0;
    logic [1:0] Tuse_rs_D = 2'd3, Tuse_rt_D = 2'd3, Tnew_D = '0;
    logic       RegWr_D = 1'b0, md_start_D = 1'b0, md_div_D = 1'b0, md_use_D = 1'b0;
    logic       stall, md_busy;
    logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;

    int checks = 0;
    int failures = 0;
    dout_t exp_q[$];

    hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk(clk), .reset(reset),
        .rs_D(rs_D), .rt_D(rt_D), .Tuse_rs_D(Tuse_rs_D), .Tuse_rt_D(Tuse_rt_D),
        .A3_D(A3_D), .RegWr_D(RegWr_D), .Tnew_D(Tnew_D),
        .md_start_D(md_start_D), .md_div_D(md_div_D), .md_use_D(md_use_D),
        .stall(stall), .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D),
        .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    function automatic din_t mkd(int rs, int tr, int rt, int tt, int a3, int wr, int tn,
                                 int mds, int mdd, int mdu);
        din_t d;
        d.rs = 5'(rs); d.tu_rs = 2'(tr); d.rt = 5'(rt); d.tu_rt = 2'(tt);
        d.a3 = 5'(a3); d.wr = 1'(wr); d.tnew = 2'(tn);
        d.mds = 1'(mds); d.mdd = 1'(mdd); d.mdu = 1'(mdu);
        return d;
    endfunction

    function automatic dout_t mko(int st, int fsd, int ftd, int fse, int fte, int busy);
        dout_t q;
        q.stall = 1'(st); q.frsd = 2'(fsd); q.frtd = 2'(ftd);
        q.frse = 2'(fse); q.frte = 2'(fte); q.busy = 1'(busy);
        return q;
    endfunction

    function automatic vec_t mk(int rs, int tr, int rt, int tt, int a3, int wr, int tn,
                                int st, int fsd, int ftd, int fse, int fte);
        vec_t v;
        v.d = mkd(rs, tr, rt, tt, a3, wr, tn, 0, 0, 0);
        v.q = mko(st, fsd, ftd, fse, fte, 0);
        return v;
    endfunction

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input din_t d);
        rs_D = d.rs; rt_D = d.rt; Tuse_rs_D = d.tu_rs; Tuse_rt_D = d.tu_rt;
        A3_D = d.a3; RegWr_D = d.wr; Tnew_D = d.tnew;
        md_start_D = d.mds; md_div_D = d.mdd; md_use_D = d.mdu;
    endtask

    task automatic compare_out(input string tag);
        dout_t e;
        if (exp_q.size() == 0) begin
            check({tag, " queue_empty"}, 8'd1, 8'd0);
            return;
        end
        e = exp_q.pop_front();
        check({tag, " stall"}, {7'd0, stall}, {7'd0, e.stall});
        check({tag, " fwd_rs_D"}, {6'd0, fwd_rs_D}, {6'd0, e.frsd});
        check({tag, " fwd_rt_D"}, {6'd0, fwd_rt_D}, {6'd0, e.frtd});
        check({tag, " fwd_rs_E"}, {6'd0, fwd_rs_E}, {6'd0, e.frse});
        check({tag, " fwd_rt_E"}, {6'd0, fwd_rt_E}, {6'd0, e.frte});
        check({tag, " md_busy"}, {7'd0, md_busy}, {7'd0, e.busy});
    endtask

    // Drive just after a rising edge, compare at the falling edge, return after the next rise.
    task automatic run_cycle(input din_t d, input dout_t e, input string tag);
        drive(d);
        exp_q.push_back(e);
        @(negedge clk);
        compare_out(tag);
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[12];

    initial begin
        din_t nop, div_i, mult_i, mfhi_i, lw8, addu8;

        nop    = mkd(0, 3, 0, 3, 0, 0, 0, 0, 0, 0);
        div_i  = mkd(0, 3, 0, 3, 0, 0, 0, 1, 1, 1);
        mult_i = mkd(0, 3, 0, 3, 0, 0, 0, 1, 0, 1);
        mfhi_i = mkd(0, 3, 0, 3, 3, 1, 1, 0, 0, 1);
        lw8    = mkd(0, 3, 0, 3, 8, 1, 2, 0, 0, 0);
        addu8  = mkd(8, 1, 0, 3, 10, 1, 1, 0, 0, 0);

        //            rs tr rt tt a3 wr tn | st fsd ftd fse fte
        tbl[0]  = mk(29, 1, 0, 3,  8, 1, 2,   0, 0, 0, 0, 0);  // lw $8
        tbl[1]  = mk( 8, 1, 9, 1, 10, 1, 1,   1, 0, 0, 0, 0);  // addu uses $8: load-use
        tbl[2]  = mk( 8, 1, 9, 1, 10, 1, 1,   0, 0, 0, 0, 0);
        tbl[3]  = mk(10, 1, 8, 1, 11, 1, 1,   0, 0, 3, 3, 0);
        tbl[4]  = mk(11, 0,10, 0,  0, 0, 0,   1, 0, 2, 2, 0);  // beq after ALU
        tbl[5]  = mk(11, 0,10, 0,  0, 0, 0,   0, 2, 3, 0, 0);
        tbl[6]  = mk( 0, 3, 0, 3,  5, 1, 1,   0, 0, 0, 3, 0);  // addu $5
        tbl[7]  = mk( 0, 3, 0, 3,  5, 1, 0,   0, 0, 0, 0, 0);  // jal-style $5
        tbl[8]  = mk( 5, 0, 5, 1,  0, 0, 0,   0, 1, 1, 0, 0);  // E beats M
        tbl[9]  = mk( 0, 3, 0, 3,  0, 1, 1,   0, 0, 0, 2, 2);  // ori $0
        tbl[10] = mk( 0, 0, 0, 0, 12, 1, 1,   0, 0, 0, 0, 0);  // reads $0
        tbl[11] = mk( 0, 3, 0, 3,  0, 0, 0,   0, 0, 0, 0, 0);

        drive(nop);
        #2;
        exp_q.push_back(mko(0, 0, 0, 0, 0, 0));
        compare_out("in_reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) run_cycle(tbl[i].d, tbl[i].q, $sformatf("row%0d", i));

        run_cycle(div_i, mko(0, 0, 0, 0, 0, 0), "div_in_D");
        for (int i = 0; i < 11; i++) run_cycle(mfhi_i, mko(1, 0, 0, 0, 0, 1), $sformatf("div_wait%0d", i));
        run_cycle(mfhi_i, mko(0, 0, 0, 0, 0, 0), "mfhi_go");
        run_cycle(nop, mko(0, 0, 0, 0, 0, 0), "mfhi_in_E");

        run_cycle(mult_i, mko(0, 0, 0, 0, 0, 0), "mult_in_D");
        for (int i = 0; i < 6; i++) run_cycle(mfhi_i, mko(1, 0, 0, 0, 0, 1), $sformatf("mult_wait%0d", i));
        run_cycle(mfhi_i, mko(0, 0, 0, 0, 0, 0), "mflo_go");
        run_cycle(nop, mko(0, 0, 0, 0, 0, 0), "mflo_in_E");

        // div leaves E, lw $8 parks in E until the counter reads 7
        run_cycle(div_i, mko(0, 0, 0, 0, 0, 0), "rst_div");
        for (int i = 0; i < 4; i++) run_cycle(lw8, mko(0, 0, 0, 0, 0, 1), $sformatf("rst_lw%0d", i));
        drive(addu8);
        exp_q.push_back(mko(1, 0, 0, 0, 0, 1));
        @(negedge clk);
        compare_out("rst_before");
        #1 reset = 1'b0;
        #1;
        exp_q.push_back(mko(0, 0, 0, 0, 0, 0));
        compare_out("rst_async");
        @(posedge clk);
        #1;
        exp_q.push_back(mko(0, 0, 0, 0, 0, 0));
        compare_out("rst_held");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        run_cycle(addu8, mko(0, 0, 0, 0, 0, 0), "rst_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
